wb_write_arbiter: RTL



---
 rtl/wb_write_arbiter_if.sv | 38 +++
 rtl/wb_write_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus: pipeline and long-latency write requests, hazard
// queries from decode, and the register file write port.
interface wb_write_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  pipe_we;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [WIDTH-1:0]      pipe_data;
  logic                  pipe_ready;
  logic                  lu_valid;
  logic [ADDR_WIDTH-1:0] lu_addr;
  logic [WIDTH-1:0]      lu_data;
  logic                  lu_ready;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic                  rs_pending;
  logic                  rt_pending;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Write_register;
  logic [WIDTH-1:0]      Write_data;
  logic [CW-1:0]         q_count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data, rs_addr, rt_addr,
    input  pipe_ready, lu_ready, rs_pending, rt_pending, RegWrite, Write_register,
           Write_data, q_count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data, rs_addr, rt_addr,
    output pipe_ready, lu_ready, rs_pending, rt_pending, RegWrite, Write_register,
           Write_data, q_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register file write port arbiter: pipeline results win each cycle, long-latency
// results wait in an in-order queue with starvation back-pressure and hazard reporting.
module wb_write_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] q_addr;
  logic [DEPTH-1:0][WIDTH-1:0]      q_data;
  logic [DEPTH-1:0]                 q_vld;
  logic [PW-1:0]                    head, tail;
  logic [CW-1:0]                    count;
  logic [WW-1:0]                    wait_cnt;

  logic empty, full, stall, pipe_fire, q_issue, push;
  logic [DEPTH-1:0] rs_hit, rt_hit, pipe_hit, push_mask, pop_mask;

  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign stall     = (wait_cnt >= LIMIT) && !empty;
  assign pipe_fire = bus.pipe_we && !stall && (bus.pipe_addr != '0);
  // Queue issue is suppressed during reset so discarded entries never reach the port.
  assign q_issue   = !pipe_fire && !empty && !rst;
  // r0 results complete the handshake but are dropped.
  assign push      = bus.lu_valid && !full && (bus.lu_addr != '0);
  assign push_mask = push    ? (DEPTH'(1) << tail) : '0;
  assign pop_mask  = q_issue ? (DEPTH'(1) << head) : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign rs_hit[i]   = q_vld[i] && (q_addr[i] == bus.rs_addr);
    assign rt_hit[i]   = q_vld[i] && (q_addr[i] == bus.rt_addr);
    assign pipe_hit[i] = q_vld[i] && (q_addr[i] == bus.pipe_addr);
  end

  assign bus.pipe_ready = !stall;
  assign bus.lu_ready   = !full;
  assign bus.q_count    = count;
  assign bus.rs_pending = (bus.rs_addr != '0) && (|rs_hit);
  assign bus.rt_pending = (bus.rt_addr != '0) && (|rt_hit);

  always_comb begin
    bus.RegWrite       = 1'b0;
    bus.Write_register = '0;
    bus.Write_data     = '0;
    if (pipe_fire) begin
      bus.RegWrite       = 1'b1;
      bus.Write_register = bus.pipe_addr;
      bus.Write_data     = bus.pipe_data;
    end else if (q_issue) begin
      bus.RegWrite       = 1'b1;
      bus.Write_register = q_addr[head];
      bus.Write_data     = q_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wait_cnt <= '0;
      q_vld    <= '0;
    end else begin
      if (push) begin
        q_addr[tail] <= bus.lu_addr;
        q_data[tail] <= bus.lu_data;
        tail         <= tail + 1'b1;
      end
      if (q_issue) head <= head + 1'b1;
      // push only targets a free slot, so it never collides with the popped head
      q_vld <= (q_vld & ~pop_mask) | push_mask;
      count <= count + CW'(push) - CW'(q_issue);
      if (q_issue || empty)     wait_cnt <= '0;
      else if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Decode must stall a pipeline write whose destination is still queued.
  a_no_pipe_over_pending: assert property (@(posedge clk) disable iff (rst)
    !(pipe_fire && (|pipe_hit)));
endmodule
